// File: rtl/mult_iter_param_if.sv
// Request/result bundle for the iterative multiplier. The execute stage is the master.
// Holds the level-held mult_begin/mult_end handshake, the operands and the product.
interface mult_iter_param_if #(
    parameter int WIDTH = 32
);
    logic               mult_begin;
    logic               mult_signed;
    logic [WIDTH-1:0]   mult_op1;
    logic [WIDTH-1:0]   mult_op2;
    logic [2*WIDTH-1:0] product;
    logic               mult_end;
    logic               mult_busy;

    modport master (
        output mult_begin, mult_signed, mult_op1, mult_op2,
        input  product, mult_end, mult_busy
    );

    modport slave (
        input  mult_begin, mult_signed, mult_op1, mult_op2,
        output product, mult_end, mult_busy
    );
endinterface

// File: rtl/mult_iter_param.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle (WIDTH must then be even).
module mult_iter_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mult_iter_param_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULT_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [PW-1:0]    acc_reg;
    logic [CW-1:0]    count_reg;
    logic             sign_reg;
    logic [PW-1:0]    product_reg;
    logic             end_reg;
    logic             busy_reg;
`ifdef MULT_RADIX4_EN
    logic [WIDTH+1:0] m3_reg;
`endif

    logic             neg1, neg2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [CW-1:0]    idx;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result_next;

    // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1) for the most negative operand.
    assign neg1 = bus.mult_signed & bus.mult_op1[WIDTH-1];
    assign neg2 = bus.mult_signed & bus.mult_op2[WIDTH-1];
    assign mag1 = neg1 ? -bus.mult_op1 : bus.mult_op1;
    assign mag2 = neg2 ? -bus.mult_op2 : bus.mult_op2;

    always_comb begin
        partial = '0;
`ifdef MULT_RADIX4_EN
        idx = CW'(WIDTH) - (count_reg << 1);
        case (mplier_reg[1:0])
            2'd1:    partial = PW'(mcand_reg);
            2'd2:    partial = PW'(mcand_reg) << 1;
            2'd3:    partial = PW'(m3_reg);
            default: partial = '0;
        endcase
`else
        idx = CW'(WIDTH) - count_reg;
        if (mplier_reg[0])
            partial = PW'(mcand_reg);
`endif
        addend      = partial << idx;
        acc_next    = acc_reg + addend;
        result_next = sign_reg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            sign_reg    <= 1'b0;
            product_reg <= '0;
            end_reg     <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef MULT_RADIX4_EN
            m3_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.mult_begin) begin
                        mcand_reg  <= mag1;
                        mplier_reg <= mag2;
                        // A zero operand never yields a negative result.
                        sign_reg   <= (neg1 ^ neg2) & (|bus.mult_op1) & (|bus.mult_op2);
                        acc_reg    <= '0;
                        count_reg  <= CW'(STEPS);
                        busy_reg   <= 1'b1;
                        state_reg  <= CALC;
`ifdef MULT_RADIX4_EN
                        m3_reg     <= (WIDTH+2)'(mag1) + ((WIDTH+2)'(mag1) << 1);
`endif
                    end
                end
                CALC: begin
                    if (!bus.mult_begin) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= acc_next;
`ifdef MULT_RADIX4_EN
                        mplier_reg <= mplier_reg >> 2;
`else
                        mplier_reg <= mplier_reg >> 1;
`endif
                        count_reg <= count_reg - 1'b1;
                        if (count_reg == CW'(1)) begin
                            product_reg <= result_next;
                            end_reg     <= 1'b1;
                            busy_reg    <= 1'b0;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.mult_begin) begin
                        end_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.product   = product_reg;
    assign bus.mult_end  = end_reg;
    assign bus.mult_busy = busy_reg;
endmodule

// File: tb/tb_mult_iter_param.sv
// Randomised self-checking bench for mult_iter_param at WIDTH=32 and WIDTH=8.
// Expected products come from native signed/unsigned arithmetic.
module tb_mult_iter_param;
    localparam int W  = 32;
    localparam int W8 = 8;
`ifdef MULT_RADIX4_EN
    localparam int LAT  = W / 2 + 1;
    localparam int LAT8 = W8 / 2 + 1;
`else
    localparam int LAT  = W + 1;
    localparam int LAT8 = W8 + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_iter_param_if #(.WIDTH(W))  bus32();
    mult_iter_param_if #(.WIDTH(W8)) bus8();

    mult_iter_param #(.WIDTH(W))  dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mult_iter_param #(.WIDTH(W8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 16'(sa * sb);
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    // Full operation on the 32-bit unit: product, latency, busy span, no early product change, handshake release.
    task automatic run32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp, prev;
        int lat, busy_cyc, early_chg;
        exp = ref32(s, a, b);
        prev = bus32.product;
        lat = 0; busy_cyc = 0; early_chg = 0;
        @(negedge clk);
        bus32.mult_begin  = 1'b1;
        bus32.mult_signed = s;
        bus32.mult_op1    = a;
        bus32.mult_op2    = b;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus32.mult_op1    = $urandom;
                bus32.mult_op2    = $urandom;
                bus32.mult_signed = ~s;
            end
            if (bus32.mult_busy) busy_cyc++;
            if (bus32.mult_end) begin
                lat = i;
                break;
            end
            if (bus32.product !== prev) early_chg++;
        end
        check({tag, "_prod"}, 128'(bus32.product), 128'(exp));
        check({tag, "_lat"}, 128'(lat), 128'(LAT));
        check({tag, "_busy"}, 128'(busy_cyc), 128'(LAT - 1));
        check({tag, "_early"}, 128'(early_chg), 128'(0));
        @(posedge clk); #1;
        check({tag, "_hold"}, 128'(bus32.mult_end), 128'(1));
        @(negedge clk);
        bus32.mult_begin = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rel"}, 128'({bus32.mult_end, bus32.mult_busy}), 128'(0));
        $display("op %s s=%0d a=%08h b=%08h product=%016h lat=%0d", tag, s, a, b, bus32.product, lat);
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp;
        int lat;
        exp = ref8(s, a, b);
        lat = 0;
        @(negedge clk);
        bus8.mult_begin  = 1'b1;
        bus8.mult_signed = s;
        bus8.mult_op1    = a;
        bus8.mult_op2    = b;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus8.mult_end) begin
                lat = i;
                break;
            end
        end
        check({tag, "_prod"}, 128'(bus8.product), 128'(exp));
        check({tag, "_lat"}, 128'(lat), 128'(LAT8));
        @(negedge clk);
        bus8.mult_begin = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rel"}, 128'(bus8.mult_end), 128'(0));
        $display("op %s s=%0d a=%02h b=%02h product=%04h lat=%0d", tag, s, a, b, bus8.product, lat);
    endtask

    task automatic abort32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prev;
        int end_seen;
        prev = bus32.product;
        end_seen = 0;
        @(negedge clk);
        bus32.mult_begin  = 1'b1;
        bus32.mult_signed = s;
        bus32.mult_op1    = a;
        bus32.mult_op2    = b;
        repeat (11) begin
            @(posedge clk); #1;
            if (bus32.mult_end) end_seen++;
        end
        check("abort_busy_mid", 128'(bus32.mult_busy), 128'(1));
        @(negedge clk);
        bus32.mult_begin = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus32.mult_end) end_seen++;
        end
        check("abort_end", 128'(end_seen), 128'(0));
        check("abort_prod", 128'(bus32.product), 128'(prev));
        check("abort_busy", 128'(bus32.mult_busy), 128'(0));
        $display("op abort a=%08h b=%08h product=%016h", a, b, bus32.product);
    endtask

    initial begin
        logic s;
        logic [31:0] a, b;
        bus32.mult_begin = 1'b0; bus32.mult_signed = 1'b0; bus32.mult_op1 = '0; bus32.mult_op2 = '0;
        bus8.mult_begin  = 1'b0; bus8.mult_signed  = 1'b0; bus8.mult_op1  = '0; bus8.mult_op2  = '0;
        #2;
        check("rst_prod", 128'(bus32.product), 128'(0));
        check("rst_end", 128'(bus32.mult_end), 128'(0));
        check("rst_busy", 128'(bus32.mult_busy), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run32("u1111", 1'b0, 32'h0000_1111, 32'h0000_1111);
        run32("s2xm1", 1'b1, 32'h0000_0002, 32'hFFFF_FFFF);
        run32("u2xm1", 1'b0, 32'h0000_0002, 32'hFFFF_FFFF);
        run32("sminxmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
        run32("s2xmin", 1'b1, 32'h0000_0002, 32'h8000_0000);
        run32("szero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        abort32(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        run32("u1111x2222", 1'b0, 32'h0000_1111, 32'h0000_2222);

        for (int k = 0; k < 20; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            run32($sformatf("rnd%0d", k), s, a, b);
        end

        // Asynchronous reset mid-operation must clear the outputs before any further edge.
        @(negedge clk);
        bus32.mult_begin = 1'b1; bus32.mult_signed = 1'b0;
        bus32.mult_op1 = 32'h0000_00FF; bus32.mult_op2 = 32'h0000_0101;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_prod", 128'(bus32.product), 128'(0));
        check("arst_end", 128'(bus32.mult_end), 128'(0));
        check("arst_busy", 128'(bus32.mult_busy), 128'(0));
        $display("op async_reset product=%016h", bus32.product);
        @(negedge clk);
        bus32.mult_begin = 1'b0;
        rst = 1'b0;

        run8("s80x7f", 1'b1, 8'h80, 8'h7F);
        for (int k = 0; k < 6; k++) begin
            s = 1'($urandom_range(0, 1));
            run8($sformatf("rnd8_%0d", k), s, 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
